// File: rtl/trivium_pkg.sv
// Trivium shared definitions: FSM encoding, register geometry, tap
// positions and the key/IV load image.
package trivium_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN
   } fsm_e;

   // Register lengths; state bit (k-1) holds s_k.
   localparam int LEN_A   = 93;
   localparam int LEN_B   = 84;
   localparam int LEN_C   = 111;
   localparam int STATE_W = LEN_A + LEN_B + LEN_C;
   localparam int A_LO    = 0;
   localparam int B_LO    = LEN_A;
   localparam int C_LO    = LEN_A + LEN_B;

   localparam int INIT_ROUNDS_DEF = 4 * STATE_W;

   // Linear output taps (s66, s93, s162, s177, s243, s288)
   localparam int TAP_A_OUT0 = 65;
   localparam int TAP_A_OUT1 = 92;
   localparam int TAP_B_OUT0 = 161;
   localparam int TAP_B_OUT1 = 176;
   localparam int TAP_C_OUT0 = 242;
   localparam int TAP_C_OUT1 = 287;
   // AND taps (s91&s92, s175&s176, s286&s287)
   localparam int TAP_A_AND0 = 90;
   localparam int TAP_A_AND1 = 91;
   localparam int TAP_B_AND0 = 174;
   localparam int TAP_B_AND1 = 175;
   localparam int TAP_C_AND0 = 285;
   localparam int TAP_C_AND1 = 286;
   // Cross feedback taps (s171, s264, s69)
   localparam int TAP_A_FB   = 170;
   localparam int TAP_B_FB   = 263;
   localparam int TAP_C_FB   = 68;

   // s178..s288 after load: all zero except s286..s288
   localparam logic [LEN_C-1:0] C_LOAD = {3'b111, 108'b0};

   // K1 lands in s1, IV1 in s94
   function automatic logic [STATE_W-1:0] load_state(input logic [79:0] key,
                                                     input logic [79:0] iv);
      return {C_LOAD, 4'b0, iv, 13'b0, key};
   endfunction

endpackage

// File: rtl/trivium_round_unroll.sv
// WORD_W Trivium rounds in one combinational cone; ks[r] is the keystream
// bit of round r+1 so the first bit of the word lands in bit 0.
module trivium_round_unroll
   import trivium_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic [STATE_W-1:0] state,
   output logic [STATE_W-1:0] next_state,
   output logic [WORD_W-1:0]  ks
);

   logic [STATE_W-1:0] st;
   logic               t1, t2, t3;

   // Rounds evaluated in order, each one seeing the previous round's shift
   always_comb begin
      st = state;
      ks = '0;
      t1 = 1'b0;
      t2 = 1'b0;
      t3 = 1'b0;
      for (int r = 0; r < WORD_W; r++) begin
         t1    = st[TAP_A_OUT0] ^ st[TAP_A_OUT1];
         t2    = st[TAP_B_OUT0] ^ st[TAP_B_OUT1];
         t3    = st[TAP_C_OUT0] ^ st[TAP_C_OUT1];
         ks[r] = t1 ^ t2 ^ t3;
         t1    = t1 ^ (st[TAP_A_AND0] & st[TAP_A_AND1]) ^ st[TAP_A_FB];
         t2    = t2 ^ (st[TAP_B_AND0] & st[TAP_B_AND1]) ^ st[TAP_B_FB];
         t3    = t3 ^ (st[TAP_C_AND0] & st[TAP_C_AND1]) ^ st[TAP_C_FB];
         st    = {st[STATE_W-2:C_LO], t2,
                  st[C_LO-2:B_LO],    t1,
                  st[B_LO-2:A_LO],    t3};
      end
      next_state = st;
   end

endmodule

// File: rtl/trivium_stream_core.sv
// Trivium keystream engine: key/IV load, warm-up, then one WORD_W-bit
// XOR per accepted input word into a one-deep output register.
module trivium_stream_core
   import trivium_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int INIT_ROUNDS = INIT_ROUNDS_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [79:0]       key_i,
   input  logic [79:0]       iv_i,
   input  logic              init_i,
   input  logic              stop_i,
   input  logic [WORD_W-1:0] in_dat_i,
   input  logic              in_vld_i,
   output logic              in_rdy_o,
   output logic [WORD_W-1:0] out_dat_o,
   output logic              out_vld_o,
   input  logic              out_rdy_i,
   output logic              ready_o
);

   localparam int INIT_CYC = INIT_ROUNDS / WORD_W;
   localparam int CNT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYC - 1);

   fsm_e               fsm_q, fsm_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STATE_W-1:0] rnd_next;
   logic [WORD_W-1:0]  rnd_ks;
   logic               accept;

   trivium_round_unroll #(.WORD_W(WORD_W)) u_rnd (
      .state      (state_q),
      .next_state (rnd_next),
      .ks         (rnd_ks)
   );

   assign ready_o  = (fsm_q == ST_IDLE);
   // One-deep output slot may be refilled in the cycle it drains
   assign in_rdy_o = (fsm_q == ST_RUN) & (~out_vld_o | out_rdy_i);
   assign accept   = in_vld_i & in_rdy_o;

   // Next-state: stop wins over everything, init only honoured in IDLE
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (stop_i) begin
         fsm_d   = ST_IDLE;
         state_d = '0;
         cnt_d   = '0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (init_i) begin
                  state_d = load_state(key_i, iv_i);
                  cnt_d   = '0;
                  fsm_d   = ST_INIT;
               end
            end
            ST_INIT: begin
               state_d = rnd_next;
               if (cnt_q == CNT_LAST) fsm_d = ST_RUN;
               else                   cnt_d = cnt_q + 1'b1;
            end
            ST_RUN: begin
               if (accept) state_d = rnd_next;
            end
            default: begin
               fsm_d   = ST_IDLE;
               state_d = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM, cipher state and warm-up counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         cnt_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output slot: load on accept, clear on drain; stop drops a pending word
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_vld_o <= 1'b0;
         out_dat_o <= '0;
      end else if (stop_i) begin
         out_vld_o <= 1'b0;
      end else if (accept) begin
         out_vld_o <= 1'b1;
         out_dat_o <= in_dat_i ^ rnd_ks;
      end else if (out_rdy_i) begin
         out_vld_o <= 1'b0;
      end
   end

endmodule
